// File: rtl/comparator_pkg.sv
// Shared result encodings, sweep state encoding and the golden unsigned compare
// used by the comparator self-test engine.
package comparator_pkg;

  localparam int RES_W    = 3;
  localparam int CMP_MAXW = 32;

  localparam logic [RES_W-1:0] RES_GT = 3'b100;
  localparam logic [RES_W-1:0] RES_EQ = 3'b010;
  localparam logic [RES_W-1:0] RES_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // Operands are zero-extended by the caller, so any WIDTH up to CMP_MAXW works.
  function automatic logic [RES_W-1:0] cmp_expected(input logic [CMP_MAXW-1:0] a,
                                                    input logic [CMP_MAXW-1:0] b);
    if (a > b) begin
      return RES_GT;
    end else if (a == b) begin
      return RES_EQ;
    end else begin
      return RES_LT;
    end
  endfunction

endpackage

// File: rtl/comparator_exp_pipe.sv
// Delay line for {valid, a, b, expected}, aligning the golden result with a
// comparator under test that has DEPTH cycles of latency.
module comparator_exp_pipe
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RES_W-1:0] in_exp,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [RES_W-1:0] out_exp
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Combinational comparator: no storage, clock/reset/clear have no effect.
      logic unused_seq;
      assign unused_seq = ^{clk, rst_n, clr};
      assign out_vld    = in_vld;
      assign out_a      = in_a;
      assign out_b      = in_b;
      assign out_exp    = in_exp;
    end else begin : g_reg
      localparam int DW = 2*WIDTH + RES_W;

      logic [DEPTH-1:0] vld_q;
      logic [DW-1:0]    dat_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= in_vld && !clr;
          dat_q[0] <= {in_a, in_b, in_exp};
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1] && !clr;
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_vld                 = vld_q[DEPTH-1];
      assign {out_a, out_b, out_exp} = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test engine for the WIDTH-bit magnitude comparator: sweeps all
// (a, b) pairs, checks the three compare flags and records the first failure.
//
//   state | meaning
//   IDLE  | waiting for start; results of a previous or aborted sweep retained
//   RUN   | driving one vector per cycle from the sweep counter
//   DRAIN | last vector held for DUT_LAT cycles until its result is checked
//   DONE  | sweep complete; done/pass/err_count/fail_* valid until start/abort
module comparator_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic               dut_gt,
  input  logic               dut_eq,
  input  logic               dut_lt,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [RES_W-1:0]   fail_res
);

  localparam int VW = 2*WIDTH;
  localparam logic [2:0] DRAIN_LOAD = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

  bist_state_t      state;
  logic [VW-1:0]    vec_cnt;
  logic [2:0]       drain_cnt;
  logic             vec_vld;
  logic             first_seen;

  logic [RES_W-1:0] exp_res;
  logic             chk_vld;
  logic [WIDTH-1:0] chk_a;
  logic [WIDTH-1:0] chk_b;
  logic [RES_W-1:0] chk_exp;
  logic [RES_W-1:0] obs_res;
  logic             mismatch;

  assign exp_res = cmp_expected(CMP_MAXW'(a_o), CMP_MAXW'(b_o));

  comparator_exp_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DUT_LAT)
  ) u_exp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort),
    .in_vld  (vec_vld),
    .in_a    (a_o),
    .in_b    (b_o),
    .in_exp  (exp_res),
    .out_vld (chk_vld),
    .out_a   (chk_a),
    .out_b   (chk_b),
    .out_exp (chk_exp)
  );

  // Expected value is always one-hot, so a non-one-hot triple can never match.
  assign obs_res  = {dut_gt, dut_eq, dut_lt};
  assign mismatch = chk_vld && (obs_res != chk_exp);
  assign pass     = done && (err_count == '0);

  // busy/done are registered from the state, so each trails its state by one
  // edge; this makes done rise on the edge that books the final check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_o        <= '0;
      b_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_res   <= '0;
      vec_cnt    <= '0;
      drain_cnt  <= '0;
      vec_vld    <= 1'b0;
      first_seen <= 1'b0;
    end else begin
      busy    <= (state == RUN) || (state == DRAIN);
      done    <= (state == DONE) && !start && !abort;
      vec_vld <= 1'b0;

      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        if (!first_seen) begin
          first_seen <= 1'b1;
          fail_a     <= chk_a;
          fail_b     <= chk_b;
          fail_res   <= obs_res;
        end
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state      <= RUN;
              vec_cnt    <= '0;
              err_count  <= '0;
              fail_a     <= '0;
              fail_b     <= '0;
              fail_res   <= '0;
              first_seen <= 1'b0;
            end
          end
          RUN: begin
            a_o     <= vec_cnt[VW-1:WIDTH];
            b_o     <= vec_cnt[WIDTH-1:0];
            vec_vld <= 1'b1;
            vec_cnt <= vec_cnt + 1'b1;
            if (vec_cnt == '1) begin
              if (DUT_LAT > 0) begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LOAD;
              end else begin
                state <= DONE;
              end
            end
          end
          DRAIN: begin
            if (drain_cnt == '0) begin
              state <= DONE;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
